// File: rtl/coherence_bus_ctrl.sv
// -----------------------------------------------------------------------------
// coherence_bus_ctrl
//
// Two-core snooping bus controller between the two data caches and the RAM
// port. Arbitrates two-word block reads and two-word write-backs round-robin.
// Every read snoops the other core: a dirty copy there is forwarded
// cache-to-cache while it is written back to RAM in the same beats, otherwise
// the block is loaded from RAM. The snooped core is asked to invalidate when
// the requester signals write intent.
//
// Parameters:
//   WORD_W   data/address width
//   RR_INIT  core treated as last-granted after reset
//
// Ports:
//   CLK, RST                        clock, synchronous active-high reset
//   dREN, dWEN, daddr, dstore       per-core request side (bit/lane i = core i)
//   cctrans, ccwrite                per-core coherence flags
//   dwait, dload                    per-core stall / read data
//   ccwait, ccinv, ccsnoopaddr      per-core snoop request side
//   ramREN, ramWEN, ramaddr,
//   ramstore, ramload, ram_ready    RAM port
//   stat_c2c, stat_inv, stat_ld     event counters
//
// Build option: define COHERENCE_STATS_EN to build the event counters;
// otherwise the stat_* ports are tied to zero.
// -----------------------------------------------------------------------------
module coherence_bus_ctrl #(
    parameter int WORD_W  = 32,
    parameter int RR_INIT = 1
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [1:0]             dREN,
    input  logic [1:0]             dWEN,
    input  logic [1:0][WORD_W-1:0] daddr,
    input  logic [1:0][WORD_W-1:0] dstore,
    input  logic [1:0]             cctrans,
    input  logic [1:0]             ccwrite,
    output logic [1:0]             dwait,
    output logic [1:0][WORD_W-1:0] dload,
    output logic [1:0]             ccwait,
    output logic [1:0]             ccinv,
    output logic [1:0][WORD_W-1:0] ccsnoopaddr,
    output logic                   ramREN,
    output logic                   ramWEN,
    output logic [WORD_W-1:0]      ramaddr,
    output logic [WORD_W-1:0]      ramstore,
    input  logic [WORD_W-1:0]      ramload,
    input  logic                   ram_ready,
    output logic [31:0]            stat_c2c,
    output logic [31:0]            stat_inv,
    output logic [31:0]            stat_ld
);

    typedef enum logic [3:0] {
        S_IDLE, S_WR1, S_WR2, S_SNP_REQ, S_SNP_RESP,
        S_C2C1, S_C2C2, S_LD1, S_LD2
    } state_e;

    state_e              state_q, state_d;
    logic                r_q, r_d;              // granted core
    logic                rr_last_q, rr_last_d;  // last-granted core
    logic [WORD_W-1:0]   snp_addr_q, snp_addr_d;
    logic                snp_inv_q, snp_inv_d;

    logic                s_idx;
    logic [1:0]          pending;
    logic                grant;
    logic                hold;

    // cctrans carries no information this controller needs
    logic                unused_cctrans;
    assign unused_cctrans = ^cctrans;

    // RAM sees only word-aligned addresses
    function automatic logic [WORD_W-1:0] word_align(input logic [WORD_W-1:0] a);
        return {a[WORD_W-1:2], 2'b00};
    endfunction

    assign s_idx   = ~r_q;
    assign pending = dREN | dWEN;
    // Tie goes to the core that was not granted last
    assign grant   = (&pending) ? ~rr_last_q : pending[1];

    // State and snoop-hold registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= S_IDLE;
            r_q        <= 1'b0;
            rr_last_q  <= 1'(RR_INIT);
            snp_addr_q <= '0;
            snp_inv_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            r_q        <= r_d;
            rr_last_q  <= rr_last_d;
            snp_addr_q <= snp_addr_d;
            snp_inv_q  <= snp_inv_d;
        end
    end

    // Next-state and output decode
    always_comb begin
        state_d     = state_q;
        r_d         = r_q;
        rr_last_d   = rr_last_q;
        snp_addr_d  = snp_addr_q;
        snp_inv_d   = snp_inv_q;
        hold        = 1'b0;
        dwait       = 2'b11;
        dload       = '0;
        ccwait      = 2'b00;
        ccinv       = 2'b00;
        ccsnoopaddr = '0;
        ramREN      = 1'b0;
        ramWEN      = 1'b0;
        ramaddr     = '0;
        ramstore    = '0;

        case (state_q)
            S_IDLE: begin
                if (|pending) begin
                    r_d       = grant;
                    rr_last_d = grant;
                    state_d   = dWEN[grant] ? S_WR1 : S_SNP_REQ;
                end else begin
                    state_d   = S_IDLE;
                end
            end
            S_WR1, S_WR2: begin
                if (!dWEN[r_q]) begin
                    state_d = S_IDLE;
                end else begin
                    ramWEN   = 1'b1;
                    ramaddr  = word_align(daddr[r_q]);
                    ramstore = dstore[r_q];
                    if (ram_ready) begin
                        dwait[r_q] = 1'b0;
                        state_d    = (state_q == S_WR1) ? S_WR2 : S_IDLE;
                    end else begin
                        state_d    = state_q;
                    end
                end
            end
            S_SNP_REQ: begin
                if (!dREN[r_q]) begin
                    state_d = S_IDLE;
                end else begin
                    // Live values this cycle, captured so they stay put afterwards
                    ccwait[s_idx]      = 1'b1;
                    ccsnoopaddr[s_idx] = daddr[r_q];
                    ccinv[s_idx]       = ccwrite[r_q];
                    snp_addr_d         = daddr[r_q];
                    snp_inv_d          = ccwrite[r_q];
                    state_d            = S_SNP_RESP;
                end
            end
            S_SNP_RESP: begin
                if (!dREN[r_q]) begin
                    state_d = S_IDLE;
                end else begin
                    hold    = 1'b1;
                    state_d = ccwrite[s_idx] ? S_C2C1 : S_LD1;
                end
            end
            S_C2C1, S_C2C2: begin
                if (!dREN[r_q]) begin
                    state_d = S_IDLE;
                end else begin
                    hold     = 1'b1;
                    ramWEN   = 1'b1;
                    ramaddr  = word_align(daddr[s_idx]);
                    ramstore = dstore[s_idx];
                    if (ram_ready) begin
                        // Write-back beat doubles as the forwarded read beat
                        dwait      = 2'b00;
                        dload[r_q] = dstore[s_idx];
                        state_d    = (state_q == S_C2C1) ? S_C2C2 : S_IDLE;
                    end else begin
                        state_d    = state_q;
                    end
                end
            end
            S_LD1, S_LD2: begin
                if (!dREN[r_q]) begin
                    state_d = S_IDLE;
                end else begin
                    hold    = 1'b1;
                    ramREN  = 1'b1;
                    ramaddr = word_align(daddr[r_q]);
                    if (ram_ready) begin
                        dwait[r_q] = 1'b0;
                        dload[r_q] = ramload;
                        state_d    = (state_q == S_LD1) ? S_LD2 : S_IDLE;
                    end else begin
                        state_d    = state_q;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Snoop outputs held from the captured values until the transaction ends
        ccwait[s_idx]      = ccwait[s_idx] | hold;
        ccinv[s_idx]       = ccinv[s_idx] | (hold & snp_inv_q);
        ccsnoopaddr[s_idx] = hold ? snp_addr_q : ccsnoopaddr[s_idx];
    end

`ifdef COHERENCE_STATS_EN
    logic [31:0] stat_c2c_q, stat_inv_q, stat_ld_q;

    // Wrapping event counters
    always_ff @(posedge CLK) begin
        if (RST) begin
            stat_c2c_q <= 32'd0;
            stat_inv_q <= 32'd0;
            stat_ld_q  <= 32'd0;
        end else begin
            stat_c2c_q <= stat_c2c_q + (((state_q == S_SNP_RESP) && (state_d == S_C2C1)) ? 32'd1 : 32'd0);
            stat_inv_q <= stat_inv_q + (((state_q == S_SNP_RESP) && ccinv[s_idx]) ? 32'd1 : 32'd0);
            stat_ld_q  <= stat_ld_q  + (((state_q == S_SNP_RESP) && (state_d == S_LD1)) ? 32'd1 : 32'd0);
        end
    end

    assign stat_c2c = stat_c2c_q;
    assign stat_inv = stat_inv_q;
    assign stat_ld  = stat_ld_q;
`else
    assign stat_c2c = 32'd0;
    assign stat_inv = 32'd0;
    assign stat_ld  = 32'd0;
`endif

endmodule

// File: doc/coherence_bus_ctrl.md
Name: coherence_bus_ctrl

Overview:
Two-core snooping bus controller that sits directly downstream of both data caches and upstream of the RAM port. It arbitrates block reads and two-word write-backs between the cores. On every read it snoops the other core. A dirty copy in the other core is served cache-to-cache and written back to RAM in the same beats; otherwise the block is loaded from RAM. It drives the invalidate request to the snooped core when the requester intends to write.

Parameters:
WORD_W, 32, data and address width
RR_INIT, 1, index of the core treated as last-granted at reset (default lets core 0 win the first tie)

Ports:
CLK  in  1  clock
RST  in  1  reset, synchronous, active-high
dREN  in  2  per-core read request (bit i = core i)
dWEN  in  2  per-core write request
daddr  in  2xWORD_W  per-core word address; bits [1:0] ignored
dstore  in  2xWORD_W  per-core write data
cctrans  in  2  per-core coherence-transaction flag
ccwrite  in  2  requester: write intent; snooper: "I hold dirty match"
dwait  out  2  per-core stall; 0 = beat completes this cycle
dload  out  2xWORD_W  per-core read data
ccwait  out  2  snoop request to core
ccinv  out  2  invalidate request to snooped core
ccsnoopaddr  out  2xWORD_W  snoop address per core
ramREN  out  1  RAM read
ramWEN  out  1  RAM write
ramaddr  out  WORD_W  RAM address
ramstore  out  WORD_W  RAM write data
ramload  in  WORD_W  RAM read data
ram_ready  in  1  RAM access completes this cycle

Behaviour:
- Reset (RST high at posedge): state IDLE, rr_last = RR_INIT. Outputs: dwait=2'b11, dload=0, ccwait=0, ccinv=0, ccsnoopaddr=0, ramREN=ramWEN=0, ramaddr=ramstore=0. Reset mid-transaction aborts immediately; there is no completion beat.
- Let r = granted core and s = the other core. dwait[i]=1 except in the completion cycles listed below.
- IDLE:
  - Pending = dREN|dWEN per core.
  - If both cores are pending, grant !rr_last. Otherwise grant the single pending core.
  - On a grant, latch r and set rr_last=r.
  - If dWEN[r] is set, go to WR1 (dWEN has priority over dREN within a core). Otherwise go to SNP_REQ.
- WR1/WR2:
  - ramWEN=1, ramaddr={daddr[r][WORD_W-1:2],2'b00}, ramstore=dstore[r].
  - When ram_ready=1: dwait[r]=0, then advance (WR1 to WR2, WR2 to IDLE).
  - No snoop is issued.
- SNP_REQ (1 cycle): ccwait[s]=1, ccsnoopaddr[s]=daddr[r], ccinv[s]=ccwrite[r]. Go to SNP_RESP.
- SNP_RESP (1 cycle): same outputs as SNP_REQ. Sample ccwrite[s]: if 1 go to C2C1, else go to LD1.
- ccwait[s], ccsnoopaddr[s] and ccinv[s] are held constant from SNP_REQ until the cycle before the return to IDLE.
- C2C1/C2C2 (snooper writes back):
  - ramWEN=1, ramaddr=daddr[s], ramstore=dstore[s].
  - When ram_ready=1: dwait[s]=0, dwait[r]=0, dload[r]=dstore[s] (forward).
  - C2C1 goes to C2C2, C2C2 goes to IDLE.
- LD1/LD2:
  - ramREN=1, ramaddr=daddr[r].
  - When ram_ready=1: dwait[r]=0, dload[r]=ramload.
  - LD1 goes to LD2, LD2 goes to IDLE.
- Abort: if the granted request (dREN[r] in snoop/LD states, dWEN[r] in WR states) drops before completion, return to IDLE next cycle. No dwait pulse; ccwait is released.
- Address bits [1:0] are never driven to RAM; beat addresses are taken from the requester/snooper each cycle.
- dload[i] is 0 whenever dwait[i]=1.
- Exactly one of ramREN/ramWEN is high, or neither. ccwait is never high on both bits.
- A request arriving from s while r is granted waits; s is snooped and stalled meanwhile.
- Latency, uncontended read with ram_ready=1 always: request cycle 0; SNP_REQ at 1; SNP_RESP at 2; beat0 completes at 3; beat1 at 4; IDLE at 5.

Optional Feature:
COHERENCE_STATS_EN
- Defined: adds outputs stat_c2c (32), stat_inv (32) and stat_ld (32). These wrapping counters increment on entry to C2C1, on SNP_RESP with ccinv[s]=1, and on entry to LD1 respectively. Reset to 0.
- Undefined: the ports still exist but are tied to 0, and no counter flops are built.

Test Plan:
- Core0 dREN, daddr=0x100, ccwrite[1]=0, ramload=0xAAAA/0xBBBB, ram_ready=1 -> ccwait[1] high cycles 1-4; ramaddr 0x100 then 0x104; dload[0]=0xAAAA at cycle 3 and 0xBBBB at cycle 4; IDLE at 5.
- Core1 dREN+ccwrite, addr 0x200; core0 asserts ccwrite in SNP_RESP with dstore 0x11/0x22 -> ccinv[0]=1; ramWEN with 0x11 then 0x22; dload[1] forwards the same values; dwait both 0 per beat.
- Both cores dWEN at reset exit, ram_ready=1 -> core0 WR1/WR2 first, then core1; next simultaneous tie goes to core0 (rr_last=1).
- ram_ready held 0 for 3 cycles during LD1 -> dwait[r] stays 1 and ramREN/ramaddr stable; completes on the first ready cycle.
- RST asserted during C2C2 -> next cycle IDLE, ccwait=0, dwait=2'b11, ramWEN=0.
- Requester drops dREN in LD2 -> IDLE next cycle, no dwait=0 pulse, ccwait released.
